// File: rtl/freq_meas_scheduler.sv
// Round-robin scheduler sharing one gated rising-edge counter across four inputs.
// Each grant runs a settle window, then a fixed gate window, then latches the count.
module freq_meas_scheduler #(
    parameter int GATE_CYCLES   = 100000000,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       in_i,
    input  logic [3:0]       req_i,
    output logic [3:0]       gnt_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] freq_o,
    output logic [1:0]       ch_o,
    output logic             ovf_o
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, LATCH} state_t;

    state_t           state_q, state_d;
    logic [3:0]       s1_q, s2_q;
    logic             prev_q;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [GW-1:0]    gate_q, gate_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic             sat_q, sat_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic [1:0]       ch_q, ch_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       rr_pick;
    logic             sel, rise;

    assign sel  = s2_q[idx_q];
    assign rise = sel & ~prev_q;

    // Scan downward so the nearest requester after the pointer wins.
    always_comb begin
        rr_pick = ptr_q;
        for (int i = 4; i >= 1; i--) begin
            if (req_i[ptr_q + 2'(i)]) rr_pick = ptr_q + 2'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        settle_d = settle_q;
        gate_d   = gate_q;
        edge_d   = edge_q;
        sat_d    = sat_q;
        gnt_d    = gnt_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        freq_d   = freq_q;
        ch_d     = ch_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    idx_d    = rr_pick;
                    gnt_d    = 4'b0001 << rr_pick;
                    busy_d   = 1'b1;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (!req_i[idx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = idx_q;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = GATE;
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            GATE: begin
                if (!req_i[idx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = idx_q;
                end else begin
                    gate_d = gate_q + GW'(1);
                    if (rise) begin
                        if (&edge_q) sat_d = 1'b1;
                        else         edge_d = edge_q + CNT_W'(1);
                    end
                    // Results register on entry to LATCH so an edge in the final gate cycle still counts.
                    if (gate_q == GATE_LAST) begin
                        state_d = LATCH;
                        valid_d = 1'b1;
                        freq_d  = edge_d;
                        ch_d    = idx_q;
                        ovf_d   = sat_d;
                        ptr_d   = idx_q;
                    end
                end
            end
            LATCH: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= 1'b0;
            idx_q    <= '0;
            ptr_q    <= 2'd3;
            settle_q <= '0;
            gate_q   <= '0;
            edge_q   <= '0;
            sat_q    <= 1'b0;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            freq_q   <= '0;
            ch_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= in_i;
            s2_q     <= s1_q;
            prev_q   <= sel;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            settle_q <= settle_d;
            gate_q   <= gate_d;
            edge_q   <= edge_d;
            sat_q    <= sat_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            freq_q   <= freq_d;
            ch_q     <= ch_d;
            ovf_q    <= ovf_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign freq_o  = freq_q;
    assign ch_o    = ch_q;
    assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Bench for freq_meas_scheduler: an 8-bit and a 4-bit instance checked against a
// reference that counts rises in the recorded input history over each gate window.
module tb_freq_meas_scheduler;
    localparam int S = 4;
    localparam int G = 100;
    localparam int M = 16383;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_v = '0;
    logic [3:0] req_a = '0, req_b = '0;
    logic [3:0] gnt_a, gnt_b;
    logic       busy_a, busy_b, valid_a, valid_b, ovf_a, ovf_b;
    logic [7:0] freq_a;
    logic [3:0] freq_b;
    logic [1:0] ch_a, ch_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [3:0] hist [0:M];
    int hi [4] = '{5, 5, 5, 5};
    int lo [4] = '{5, 5, 5, 5};
    int pos [4] = '{0, 0, 0, 0};
    logic [1:0] ptr [2];
    int last_freq, last_ch;

    freq_meas_scheduler #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8)) dut_a (
        .clk_i(clk), .reset_i(rst_n), .in_i(in_v), .req_i(req_a),
        .gnt_o(gnt_a), .busy_o(busy_a), .valid_o(valid_a), .freq_o(freq_a),
        .ch_o(ch_a), .ovf_o(ovf_a));

    freq_meas_scheduler #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4)) dut_b (
        .clk_i(clk), .reset_i(rst_n), .in_i(in_v), .req_i(req_b),
        .gnt_o(gnt_b), .busy_o(busy_b), .valid_o(valid_b), .freq_o(freq_b),
        .ch_o(ch_b), .ovf_o(ovf_b));

    always #5 clk = ~clk;

    // hist[n] is the input value sampled at rising edge number n.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        hist[(cyc + 1) & M] <= in_v;
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (pos[k] >= hi[k] + lo[k] - 1) pos[k] = 0;
                else pos[k] = pos[k] + 1;
                in_v[k] = (pos[k] < hi[k]);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_wave(input int k, input int h, input int l);
        hi[k] = h;
        lo[k] = l;
        pos[k] = 0;
    endtask

    function automatic logic [1:0] rr(input logic [1:0] p, input logic [3:0] r);
        for (int i = 1; i <= 4; i++)
            if (r[(int'(p) + i) % 4]) return 2'((int'(p) + i) % 4);
        return p;
    endfunction

    // Two-cycle synchronizer delay: edge n counts a rise seen between samples n-3 and n-2.
    function automatic int rises(input int ch, input int t);
        int c = 0;
        for (int n = t + S + 1; n <= t + S + G; n++)
            if (hist[(n - 2) & M][ch] && !hist[(n - 3) & M][ch]) c++;
        return c;
    endfunction

    // Called at a negedge; the next rising edge is the one at which IDLE samples REQ.
    task automatic meas(input bit b, input logic [1:0] ch, input bit hold);
        int t, n, early, maxc;
        t = cyc + 1;
        @(negedge clk);
        chk("gnt", b ? gnt_b : gnt_a, 4'b0001 << ch);
        chk("busy", b ? busy_b : busy_a, 1);
        early = 0;
        repeat (S + G - 1) begin
            @(negedge clk);
            if ((b ? valid_b : valid_a) === 1'b1) early++;
        end
        chk("early_valid", early, 0);
        @(negedge clk);
        n = rises(ch, t);
        maxc = b ? 15 : 255;
        chk("valid", b ? valid_b : valid_a, 1);
        chk("freq", b ? freq_b : freq_a, (n > maxc) ? maxc : n);
        chk("ch", b ? ch_b : ch_a, ch);
        chk("ovf", b ? ovf_b : ovf_a, n > maxc);
        if (!b) begin
            last_freq = (n > maxc) ? maxc : n;
            last_ch = ch;
        end
        if (!hold) begin
            if (b) req_b = '0;
            else req_a = '0;
        end
        @(negedge clk);
        chk("valid_pulse", b ? valid_b : valid_a, 0);
        chk("gnt_idle", b ? gnt_b : gnt_a, 0);
        chk("busy_idle", b ? busy_b : busy_a, 0);
        ptr[b] = ch;
    endtask

    initial begin
        logic [1:0] c1;
        logic [3:0] r;

        // Reset with random activity on the inputs
        for (int k = 0; k < 4; k++) set_wave(k, $urandom_range(2, 6), $urandom_range(2, 6));
        for (int i = 0; i < 3; i++) begin
            req_a = 4'($urandom);
            req_b = 4'($urandom);
            @(negedge clk);
            chk("rst_gnt", gnt_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_valid", valid_a, 0);
            chk("rst_freq", freq_a, 0);
            chk("rst_ch", ch_a, 0);
            chk("rst_ovf", ovf_a, 0);
            chk("rst_gnt_b", gnt_b, 0);
        end
        rst_n = 1'b1;
        req_a = '0;
        req_b = '0;
        ptr[0] = 2'd3;
        ptr[1] = 2'd3;
        @(negedge clk);

        // Round robin with all requests held
        for (int k = 0; k < 4; k++) set_wave(k, 5 * (k + 1), 5 * (k + 1));
        req_a = 4'hF;
        for (int i = 0; i < 5; i++) begin
            c1 = rr(ptr[0], 4'hF);
            chk("rr_order", c1, i % 4);
            meas(1'b0, c1, i < 4);
        end

        // Single channel
        set_wave(0, 5, 5);
        req_a = 4'b0001;
        meas(1'b0, rr(ptr[0], 4'b0001), 1'b0);
        chk("single_freq", freq_a, 10);

        // Saturation on the 4-bit instance, then a normal run
        set_wave(1, 2, 2);
        req_b = 4'b0010;
        meas(1'b1, rr(ptr[1], 4'b0010), 1'b0);
        chk("sat_freq", freq_b, 15);
        chk("sat_ovf", ovf_b, 1);
        set_wave(1, 5, 5);
        req_b = 4'b0010;
        meas(1'b1, rr(ptr[1], 4'b0010), 1'b0);
        chk("unsat_ovf", ovf_b, 0);

        // Abort channel 1 mid-gate, channel 2 follows
        req_a = 4'b0110;
        c1 = rr(ptr[0], 4'b0110);
        @(negedge clk);
        chk("abort_gnt", gnt_a, 4'b0001 << c1);
        repeat (S + 49) @(negedge clk);
        req_a = 4'b0100;
        @(negedge clk);
        chk("abort_gnt0", gnt_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_valid", valid_a, 0);
        chk("abort_freq", freq_a, last_freq);
        chk("abort_ch", ch_a, last_ch);
        ptr[0] = c1;
        meas(1'b0, rr(ptr[0], 4'b0100), 1'b0);

        // Reset in the middle of a gate window
        req_a = 4'b0001;
        @(negedge clk);
        repeat (S + 20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_gnt", gnt_a, 0);
        chk("mid_rst_freq", freq_a, 0);
        chk("mid_rst_valid", valid_a, 0);
        rst_n = 1'b1;
        ptr[0] = 2'd3;
        ptr[1] = 2'd3;
        meas(1'b0, rr(ptr[0], 4'b0001), 1'b0);

        // Randomized requests and input waveforms
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 4; k++) set_wave(k, $urandom_range(2, 9), $urandom_range(2, 9));
            r = 4'($urandom_range(1, 15));
            req_a = r;
            meas(1'b0, rr(ptr[0], r), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
